// File: rtl/sysid_regfile.sv
`default_nettype none
// ============================================================================
// Module   : sysid_regfile
// Brief    : System-ID Avalon-MM slave. 32-bit register file with a fixed
//            one-cycle read latency: ID, build timestamp, info word, RW
//            scratch and an optional 64-bit uptime counter.
//            Optional feature macro: SYSID_UPTIME_EN (uptime counter,
//            prescaler, HI shadow and UPTIME_CTRL; INFO[0]=1 when present).
// Revision : 1.0 - initial release
// ============================================================================
module sysid_regfile #(
  parameter logic [31:0] SYSTEM_ID   = 32'h51279DF8,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter logic [15:0] VERSION     = 16'd2,
  parameter logic [31:0] SCRATCH_RST = 32'h0,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned ADDR_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [ADDR_W-1:0] c_ADDR_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_ADDR_TS      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_SCRATCH = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_ADDR_INFO    = ADDR_W'(3);

  // Elaboration-time guard against unsupported parameter values.
  if ((PRESCALE == 0) || (PRESCALE > 65535) || (ADDR_W < 3)) begin : g_param_check
    $error("sysid_regfile: illegal PRESCALE or ADDR_W");
  end

  logic [31:0] r_readdata;
  logic        r_readdatavalid;
  logic [31:0] r_scratch;
  logic [31:0] w_rdata;
  logic [31:0] w_wmask;
  logic [31:0] w_info;
  logic        w_present;
  logic        w_scratch_wr;

  assign w_wmask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                    {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign w_scratch_wr = write && (address == c_ADDR_SCRATCH);

`ifdef SYSID_UPTIME_EN
  localparam logic [ADDR_W-1:0] c_ADDR_UP_LO = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_ADDR_UP_HI = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] c_ADDR_CTRL  = ADDR_W'(6);
  localparam logic [15:0]       c_PRESC_LAST = 16'(PRESCALE - 1);

  logic [63:0] r_uptime;
  logic [15:0] r_presc;
  logic [31:0] r_hi_shadow;
  logic        r_freeze;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_lo_rd;

  assign w_present = 1'b1;
  // Control bits live in byte lane 0, so only that lane can update them.
  assign w_ctrl_wr = write && (address == c_ADDR_CTRL) && byteenable[0];
  assign w_clear   = w_ctrl_wr && writedata[0];
  assign w_lo_rd   = read && (address == c_ADDR_UP_LO);

  // Uptime counter and prescaler; CLEAR takes priority over counting,
  // FREEZE (as held before this edge) stalls both.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_uptime <= 64'd0;
      r_presc  <= 16'd0;
      r_freeze <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_freeze <= writedata[1];
      end
      if (w_clear) begin
        r_uptime <= 64'd0;
        r_presc  <= 16'd0;
      end else if (!r_freeze) begin
        if (r_presc == c_PRESC_LAST) begin
          r_presc  <= 16'd0;
          r_uptime <= r_uptime + 64'd1;
        end else begin
          r_presc <= r_presc + 16'd1;
        end
      end
    end
  end

  // Reading the low word snapshots the high word so a LO-then-HI pair is coherent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi_shadow <= 32'd0;
    end else if (w_lo_rd) begin
      r_hi_shadow <= r_uptime[63:32];
    end
  end
`else
  assign w_present = 1'b0;
`endif

  assign w_info = {VERSION, 8'h00, 7'b0, w_present};

  // Read multiplexer; unmapped words return zero.
  always_comb begin
    w_rdata = 32'd0;
    case (address)
      c_ADDR_ID:      w_rdata = SYSTEM_ID;
      c_ADDR_TS:      w_rdata = TIMESTAMP;
      c_ADDR_SCRATCH: w_rdata = r_scratch;
      c_ADDR_INFO:    w_rdata = w_info;
`ifdef SYSID_UPTIME_EN
      c_ADDR_UP_LO:   w_rdata = r_uptime[31:0];
      c_ADDR_UP_HI:   w_rdata = r_hi_shadow;
      c_ADDR_CTRL:    w_rdata = {30'd0, r_freeze, 1'b0};
`endif
      default:        w_rdata = 32'd0;
    endcase
  end

  // Scratch register with per-byte write lanes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scratch <= SCRATCH_RST;
    end else if (w_scratch_wr) begin
      r_scratch <= (r_scratch & ~w_wmask) | (writedata & w_wmask);
    end
  end

  // Registered read response; data is sampled before any same-edge write lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_readdata      <= 32'd0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= read;
      if (read) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;

endmodule
`default_nettype wire

// File: tb/tb_sysid_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_regfile
// Brief    : Self-checking bench for sysid_regfile. A register-level model
//            predicts every read response; directed vectors add literal
//            expectations. Uptime scenarios build only with SYSID_UPTIME_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_regfile;

  localparam logic [31:0] SYSID    = 32'h51279DF8;
  localparam logic [31:0] TSTAMP   = 32'd0;
  localparam logic [31:0] SCR_RST  = 32'h0;
  localparam int          PRESC    = 4;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] INFO_EXP = 32'h0002_0001;
`else
  localparam logic [31:0] INFO_EXP = 32'h0002_0000;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  sysid_regfile #(
    .SYSTEM_ID   (SYSID),
    .TIMESTAMP   (TSTAMP),
    .VERSION     (16'd2),
    .SCRATCH_RST (SCR_RST),
    .PRESCALE    (PRESC),
    .ADDR_W      (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Uptime is modelled as base + (unfrozen clock ticks since base) / PRESC.
  logic [31:0] m_rd;
  logic        m_rdv;
  logic [31:0] m_scratch;
  logic        m_freeze;
  logic [31:0] m_shadow;
  logic [63:0] m_base;
  logic [63:0] m_ticks;
  logic        dep_req = 1'b0;
  logic [63:0] dep_val = 64'd0;
  logic [63:0] w_base;
  logic [63:0] w_ticks;
  logic [63:0] w_cnt;

  assign w_base  = dep_req ? dep_val : m_base;
  assign w_ticks = dep_req ? 64'd0 : m_ticks;
`ifdef SYSID_UPTIME_EN
  assign w_cnt   = w_base + (w_ticks / 64'(PRESC));
`else
  assign w_cnt   = 64'd0;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_val(input logic [2:0] a, input logic [31:0] scr,
                                          input logic frz, input logic [63:0] cnt,
                                          input logic [31:0] shd);
    case (a)
      3'd0: return SYSID;
      3'd1: return TSTAMP;
      3'd2: return scr;
      3'd3: return INFO_EXP;
`ifdef SYSID_UPTIME_EN
      3'd4: return cnt[31:0];
      3'd5: return shd;
      3'd6: return {30'd0, frz, 1'b0};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Model state update on every edge, including asynchronous reset.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_rd <= 32'd0; m_rdv <= 1'b0; m_scratch <= SCR_RST;
      m_freeze <= 1'b0; m_shadow <= 32'd0; m_base <= 64'd0; m_ticks <= 64'd0;
    end else begin
      m_rdv <= read;
      if (read) m_rd <= exp_val(address, m_scratch, m_freeze, w_cnt, m_shadow);
      if (write && address == 3'd2) m_scratch <= merge(m_scratch, writedata, byteenable);
`ifdef SYSID_UPTIME_EN
      if (read && address == 3'd4) m_shadow <= w_cnt[63:32];
      if (write && address == 3'd6 && byteenable[0]) m_freeze <= writedata[1];
      if (write && address == 3'd6 && byteenable[0] && writedata[0]) begin
        m_base <= 64'd0; m_ticks <= 64'd0;
      end else begin
        m_base <= w_base; m_ticks <= w_ticks + (m_freeze ? 64'd0 : 64'd1);
      end
`endif
    end
  end

  // Compare process: outputs against the model every cycle.
  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      check("model_rdv", {63'd0, readdatavalid}, {63'd0, m_rdv});
      check("model_rdata", {32'd0, readdata}, {32'd0, m_rd});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rd_get(input logic [2:0] a, output logic [31:0] v);
    @(negedge clock); read = 1'b1; address = a;
    @(posedge clock); #1; v = readdata;
    @(negedge clock); read = 1'b0;
  endtask

  task automatic rd_expect(input logic [2:0] a, input logic [31:0] e, input string name);
    logic [31:0] v;
    rd_get(a, v);
    check(name, {32'd0, v}, {32'd0, e});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock); write = 1'b1; address = a; writedata = d; byteenable = be;
    @(negedge clock); write = 1'b0;
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e,
                    input string name);
    @(negedge clock); read = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = 4'hF;
    @(posedge clock); #1; check(name, {32'd0, readdata}, {32'd0, e});
    @(negedge clock); read = 1'b0; write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 3'd0;
    writedata = 32'd0; byteenable = 4'h0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rdv", {63'd0, readdatavalid}, 64'd0);
    check("reset_rdata", {32'd0, readdata}, 64'd0);
    @(negedge clock); reset = 1'b0; chk_en = 1'b1;

    rd_expect(3'd0, 32'h51279DF8, "id");
    rd_expect(3'd1, 32'h0000_0000, "timestamp");
    rd_expect(3'd3, INFO_EXP, "info");
    wr(3'd2, 32'hAABBCCDD, 4'b0101);
    rd_expect(3'd2, 32'h00BB00DD, "scratch_be");
    rd_expect(3'd7, 32'h0, "reserved7");
    wr(3'd0, 32'h12345678, 4'hF);
    rd_expect(3'd0, 32'h51279DF8, "id_ro");
    wr(3'd2, 32'h1, 4'hF);
    rw(3'd2, 32'h2, 32'h1, "rw_old");
    rd_expect(3'd2, 32'h2, "rw_new");

`ifdef SYSID_UPTIME_EN
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    repeat (40) @(posedge clock);
    rd_get(3'd4, v1);
    check("uptime_40clk", {63'd0, (v1 >= 32'd9 && v1 <= 32'd11)}, 64'd1);
    wr(3'd6, 32'h2, 4'h1);
    rd_expect(3'd6, 32'h2, "ctrl_freeze");
    rd_get(3'd4, v1);
    repeat (20) @(posedge clock);
    rd_get(3'd4, v2);
    check("freeze_hold", {32'd0, v2}, {32'd0, v1});
    wr(3'd6, 32'h1, 4'h1);
    rd_expect(3'd4, 32'h0, "clear_lo");
    rd_expect(3'd6, 32'h0, "ctrl_after_clear");
    // Deposit the counter just below the 32-bit boundary.
    @(posedge clock); #2;
    dut.r_uptime = 64'h0000_0000_FFFF_FFFF;
    dut.r_presc  = 16'd0;
    dep_val = 64'h0000_0000_FFFF_FFFF; dep_req = 1'b1;
    @(negedge clock); read = 1'b1; address = 3'd4;
    @(posedge clock); #1; dep_req = 1'b0;
    check("wrap_lo", {32'd0, readdata}, 64'hFFFF_FFFF);
    @(negedge clock); address = 3'd5;
    @(posedge clock); #1;
    check("wrap_hi_shadow", {32'd0, readdata}, 64'd0);
    @(negedge clock); read = 1'b0;
    repeat (4) @(posedge clock);
    rd_get(3'd4, v1);
    rd_expect(3'd5, 32'h1, "wrap_hi_after");
    wr(3'd6, 32'h1, 4'h1);
    rd_expect(3'd5, 32'h1, "clear_keeps_shadow");
`else
    wr(3'd4, 32'hFFFF_FFFF, 4'hF);
    wr(3'd6, 32'hFFFF_FFFF, 4'hF);
    rd_expect(3'd4, 32'h0, "noup_w4");
    rd_expect(3'd5, 32'h0, "noup_w5");
    rd_expect(3'd6, 32'h0, "noup_w6");
`endif

    // Reset arriving while a read response is being presented.
    @(negedge clock); read = 1'b1; address = 3'd0;
    @(posedge clock); #3; reset = 1'b1;
    #1;
    check("rst_mid_rdv", {63'd0, readdatavalid}, 64'd0);
    check("rst_mid_rdata", {32'd0, readdata}, 64'd0);
    @(negedge clock); read = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    rd_expect(3'd2, 32'h0, "scratch_after_reset");

    repeat (2) @(posedge clock);
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
